// File: rtl/pre_alloc_pkg.sv
// Shared helpers for the multi-port entry pre-allocator.
// Pure functions only; no state, no latency.
// No flow control here; callers own all handshakes.
package pre_alloc_pkg;

    // Widest handshake vector the lead-ones counter accepts (OUT_NUM bound).
    localparam int unsigned LO_MAX_W = 32;

    // Number of consecutive ones starting at bit 0, looking at the low n bits.
    function automatic int unsigned lead_ones_cnt(input logic [LO_MAX_W-1:0] v,
                                                  input int unsigned n);
        int unsigned cnt;
        logic        run;
        cnt = 0;
        run = 1'b1;
        for (int unsigned i = 0; i < LO_MAX_W; i++) begin
            if (i < n && run) begin
                if (v[i]) cnt = cnt + 1;
                else      run = 1'b0;
            end
        end
        return cnt;
    endfunction

    // Circular pointer advance with explicit wrap; step must not exceed depth,
    // so one subtraction is enough and depth need not be a power of two.
    function automatic int unsigned ptr_adv(input int unsigned ptr,
                                            input int unsigned step,
                                            input int unsigned depth);
        int unsigned s;
        s = ptr + step;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

endpackage

// File: rtl/cmn_lead_one.sv
// Priority encoder: lowest set bit of vec_i as one-hot and binary index.
// Purely combinational, zero latency.
// No flow control; vld_o is low when the vector is empty.
module cmn_lead_one #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [WIDTH-1:0] oh_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        oh_o  = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                oh_o    = '0;
                oh_o[i] = 1'b1;
                idx_o   = IDX_W'(i);
                vld_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pre_alloc_multi.sv
// Claims one free pool entry per cycle into a circular prefetch buffer and shows the oldest IDs on OUT_NUM in-order ports.
// Claim-to-output 1 cycle (no bypass); flush-to-release 1 cycle.
// Claim stalls while the registered count is full; ports pop as a ready prefix, up to OUT_NUM per cycle.
module pre_alloc_multi
    import pre_alloc_pkg::*;
#(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int PRE_ALLO_DEPTH = 4,
    parameter int OUT_NUM        = 2,
    parameter int CNT_WIDTH      = $clog2(PRE_ALLO_DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [ENTRY_NUM-1:0]                   v_in_vld,
    output logic [ENTRY_NUM-1:0]                   v_in_rdy,
    output logic [OUT_NUM-1:0]                     v_out_vld,
    input  logic [OUT_NUM-1:0]                     v_out_rdy,
    output logic [OUT_NUM-1:0][ENTRY_ID_WIDTH-1:0] v_out_index,
    input  logic                                   flush,
    output logic [ENTRY_NUM-1:0]                   v_release,
    output logic [CNT_WIDTH-1:0]                   avail_cnt
);

    localparam int PTR_W = (PRE_ALLO_DEPTH > 1) ? $clog2(PRE_ALLO_DEPTH) : 1;

    logic [ENTRY_NUM-1:0]      cand_oh;
    logic [ENTRY_ID_WIDTH-1:0] cand_id;
    logic                      cand_vld;

    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ENTRY_NUM-1:0]      v_release_q, v_release_d;
    logic [ENTRY_ID_WIDTH-1:0] buf_q [PRE_ALLO_DEPTH];
    logic [ENTRY_ID_WIDTH-1:0] buf_d [PRE_ALLO_DEPTH];

    logic                      claim;
    logic [CNT_WIDTH-1:0]      pop_n;
    logic [OUT_NUM-1:0]        rdy_inc;
    logic                      rdy_prefix_ok;

    cmn_lead_one #(
        .WIDTH (ENTRY_NUM),
        .IDX_W (ENTRY_ID_WIDTH)
    ) u_lead_one (
        .vec_i (v_in_vld),
        .oh_o  (cand_oh),
        .idx_o (cand_id),
        .vld_o (cand_vld)
    );

    // Full test uses the registered count, so a slot popped this cycle is reused next cycle.
    assign claim    = cand_vld && (int'(cnt_q) < PRE_ALLO_DEPTH) && !flush && rst_n;
    assign v_in_rdy = claim ? cand_oh : '0;

    // Ready must be a thermometer from port 0: adding one to it clears every set bit.
    assign rdy_inc       = v_out_rdy + OUT_NUM'(1);
    assign rdy_prefix_ok = ((rdy_inc & v_out_rdy) == '0);

    // Next state: flush drops everything and reports it; otherwise claim and pop together.
    always_comb begin
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        v_release_d = '0;
        pop_n       = '0;
        buf_d       = buf_q;
        if (flush) begin
            for (int i = 0; i < PRE_ALLO_DEPTH; i++) begin
                if (i < int'(cnt_q)) begin
                    v_release_d[buf_q[PTR_W'(ptr_adv(32'(rd_ptr_q), 32'(i), PRE_ALLO_DEPTH))]] = 1'b1;
                end
            end
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            pop_n = CNT_WIDTH'(lead_ones_cnt(LO_MAX_W'(v_out_vld & v_out_rdy), OUT_NUM));
            if (claim) begin
                buf_d[wr_ptr_q] = cand_id;
                wr_ptr_d        = PTR_W'(ptr_adv(32'(wr_ptr_q), 32'd1, PRE_ALLO_DEPTH));
            end
            rd_ptr_d = PTR_W'(ptr_adv(32'(rd_ptr_q), 32'(pop_n), PRE_ALLO_DEPTH));
            cnt_d    = cnt_q + CNT_WIDTH'(claim) - pop_n;
        end
    end

    // Control state: occupancy, pointers and the one-cycle release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            v_release_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            v_release_q <= v_release_d;
        end
    end

    // ID storage; slots beyond the occupancy are don't-care, so no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Ports show the oldest IDs in order; validity depends only on occupancy.
    always_comb begin
        v_out_vld   = '0;
        v_out_index = '0;
        for (int k = 0; k < OUT_NUM; k++) begin
            v_out_vld[k]   = (int'(cnt_q) > k);
            v_out_index[k] = buf_q[PTR_W'(ptr_adv(32'(rd_ptr_q), 32'(k), PRE_ALLO_DEPTH))];
        end
    end

    assign v_release = v_release_q;
    assign avail_cnt = cnt_q;

    // Flag consumers that present a ready bit above a clear one.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (rdy_prefix_ok)
            else $warning("pre_alloc_multi: v_out_rdy %b is not a contiguous prefix from port 0", v_out_rdy);
        end
    end

endmodule
